// File: rtl/tone_generator.sv
// tone_generator: timed square-wave direction tone (IDLE -> BURST -> GAP -> IDLE).
// Optional macro TONE_GEN_PREEMPT_EN lets a new command restart an in-progress tone.
`default_nettype none

module tone_generator #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BURST_CYCLES = 30_000_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enableToneGen,
    input  logic       cmdValid,
    input  logic [2:0] cmdDir,
    output logic       cmdReady,
    output logic       toneOut,
    output logic       busy,
    output logic [2:0] curDir,
    output logic       donePulse,
    output logic       badCmd
);

    localparam logic [2:0] TD_HOLD    = 3'd0;
    localparam logic [2:0] TD_FORWARD = 3'd1;
    localparam logic [2:0] TD_REVERSE = 3'd2;
    localparam logic [2:0] TD_LEFT    = 3'd3;
    localparam logic [2:0] TD_RIGHT   = 3'd4;
    localparam logic [2:0] TD_STOP    = 3'd5;

    localparam logic [24:0] BURST_LAST = 25'(BURST_CYCLES - 1);
    localparam logic [24:0] GAP_LAST   = 25'(GAP_CYCLES - 1);

    // Both durations must fit the 25-bit counters; CLK_HZ is informational only.
    if (CLK_HZ < 1 || BURST_CYCLES < 1 || BURST_CYCLES > 2**25 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 2**25) begin : g_param_check
        $error("tone_generator: CLK_HZ, BURST_CYCLES or GAP_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         cmd_mapped;
    logic [14:0]  cmd_half;
    logic         start_burst;
    logic         end_burst;
    logic         end_gap;
    logic         reject;
    logic [14:0]  half_last;
    logic [14:0]  half_cnt;
    logic [24:0]  burst_cnt;
    logic [24:0]  gap_cnt;

`ifdef TONE_GEN_PREEMPT_EN
    assign cmdReady = enableToneGen;
`else
    assign cmdReady = (state == IDLE) && enableToneGen;
`endif

    assign accept = cmdValid && cmdReady;

    // Half-period in clocks; zero marks a code with no tone.
    always_comb begin
        cmd_half = 15'd0;
        case (cmdDir)
            TD_STOP:    cmd_half = 15'd25000;
            TD_FORWARD: cmd_half = 15'd16667;
            TD_LEFT:    cmd_half = 15'd12500;
            TD_RIGHT:   cmd_half = 15'd10000;
            TD_REVERSE: cmd_half = 15'd8333;
            default:    cmd_half = 15'd0;
        endcase
    end

    assign cmd_mapped = (cmd_half != 15'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_burst = 1'b0;
        end_burst   = 1'b0;
        end_gap     = 1'b0;
        reject      = accept && !cmd_mapped;
        if (!enableToneGen) begin
            state_next = IDLE;
        end else if (accept && cmd_mapped) begin
            start_burst = 1'b1;
            state_next  = BURST;
        end else begin
            case (state)
                BURST: if (burst_cnt == BURST_LAST) begin
                    end_burst  = 1'b1;
                    state_next = GAP;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    end_gap    = 1'b1;
                    state_next = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toneOut   <= 1'b0;
            busy      <= 1'b0;
            curDir    <= TD_HOLD;
            donePulse <= 1'b0;
            badCmd    <= 1'b0;
            half_last <= 15'd0;
            half_cnt  <= 15'd0;
            burst_cnt <= 25'd0;
            gap_cnt   <= 25'd0;
        end else begin
            donePulse <= end_gap;
            badCmd    <= reject;
            busy      <= (state_next != IDLE);
            if (!enableToneGen) begin
                toneOut   <= 1'b0;
                curDir    <= TD_HOLD;
                half_cnt  <= 15'd0;
                burst_cnt <= 25'd0;
                gap_cnt   <= 25'd0;
            end else if (start_burst) begin
                toneOut   <= 1'b1;
                curDir    <= cmdDir;
                half_last <= cmd_half - 15'd1;
                half_cnt  <= 15'd0;
                burst_cnt <= 25'd0;
                gap_cnt   <= 25'd0;
            end else if (end_burst) begin
                toneOut   <= 1'b0;
                half_cnt  <= 15'd0;
                burst_cnt <= 25'd0;
                gap_cnt   <= 25'd0;
            end else if (end_gap) begin
                curDir  <= TD_HOLD;
                gap_cnt <= 25'd0;
            end else if (state == BURST) begin
                burst_cnt <= burst_cnt + 25'd1;
                if (half_cnt == half_last) begin
                    toneOut  <= ~toneOut;
                    half_cnt <= 15'd0;
                end else begin
                    half_cnt <= half_cnt + 15'd1;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 25'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tone_generator.sv
// tb_tone_generator: directed, self-checking bench for tone_generator with shortened durations.
`default_nettype none

module tb_tone_generator;

    localparam int BURST = 26_000;
    localparam int GAP   = 200;

    localparam logic [2:0] TD_HOLD    = 3'd0;
    localparam logic [2:0] TD_FORWARD = 3'd1;
    localparam logic [2:0] TD_REVERSE = 3'd2;
    localparam logic [2:0] TD_RIGHT   = 3'd4;
    localparam logic [2:0] TD_STOP    = 3'd5;

`ifdef TONE_GEN_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       valid;
    logic [2:0] dir;
    logic       ready;
    logic       tone;
    logic       busy;
    logic [2:0] cur_dir;
    logic       done;
    logic       bad;

    int checks = 0;
    int errors = 0;
    int pos    = 0;
    int done_count = 0;

    tone_generator #(
        .CLK_HZ(50_000_000),
        .BURST_CYCLES(BURST),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enableToneGen(en),
        .cmdValid(valid),
        .cmdDir(dir),
        .cmdReady(ready),
        .toneOut(tone),
        .busy(busy),
        .curDir(cur_dir),
        .donePulse(done),
        .badCmd(bad)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        pos += n;
    endtask

    task automatic go_to(input int target);
        step(target - pos);
    endtask

    task automatic start_cmd(input logic [2:0] d);
        dir   = d;
        valid = 1'b1;
        #1;
        check_val("ready_before_accept", ready, 1);
        step(1);
        valid = 1'b0;
        pos   = 0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_tone"}, tone, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_dir"}, cur_dir, TD_HOLD);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_bad"}, bad, 0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; valid = 1'b0; dir = TD_HOLD;
        #1;
        check_idle("reset");
        check_val("reset_ready", ready, 0);
        step(3);
        rst = 1'b1;
        step(2);
        check_idle("post_reset");

        // Request while disabled must not be taken.
        dir = TD_STOP; valid = 1'b1;
        step(1);
        check_val("disabled_busy", busy, 0);
        valid = 1'b0; en = 1'b1;
        #1;
        check_val("ready_after_enable", ready, 1);

        // Unmapped codes: HOLD and 7.
        dir = TD_HOLD; valid = 1'b1;
        step(1);
        valid = 1'b0;
        check_val("hold_bad", bad, 1);
        check_val("hold_busy", busy, 0);
        check_val("hold_tone", tone, 0);
        step(1);
        check_val("hold_bad_clear", bad, 0);
        check_val("hold_busy_later", busy, 0);
        dir = 3'd7; valid = 1'b1;
        step(1);
        valid = 1'b0;
        check_val("code7_bad", bad, 1);
        check_val("code7_busy", busy, 0);
        step(1);

        // Full REVERSE burst and gap.
        start_cmd(TD_REVERSE);
        check_val("rev_tone0", tone, 1);
        check_val("rev_busy0", busy, 1);
        check_val("rev_dir0", cur_dir, TD_REVERSE);
        check_val("rev_bad0", bad, 0);
        check_val("rev_ready_busy", ready, PREEMPT ? 1 : 0);
        go_to(8332);  check_val("rev_8332", tone, 1);
        go_to(8333);  check_val("rev_8333", tone, 0);
        go_to(16665); check_val("rev_16665", tone, 0);
        go_to(16666); check_val("rev_16666", tone, 1);
        go_to(24998); check_val("rev_24998", tone, 1);
        go_to(24999); check_val("rev_24999", tone, 0);
        go_to(BURST - 1); check_val("rev_last_burst_busy", busy, 1);
        go_to(BURST);
        check_val("rev_gap_busy", busy, 1);
        check_val("rev_gap_tone", tone, 0);
        check_val("rev_gap_dir", cur_dir, TD_REVERSE);
        go_to(BURST + GAP - 1);
        check_val("rev_gap_end_busy", busy, 1);
        check_val("rev_gap_end_done", done, 0);
        go_to(BURST + GAP);
        check_val("rev_done", done, 1);
        check_val("rev_idle_busy", busy, 0);
        check_val("rev_idle_dir", cur_dir, TD_HOLD);
        check_val("rev_idle_ready", ready, 1);
        go_to(BURST + GAP + 1);
        check_val("rev_done_clear", done, 0);
        check_val("rev_done_count", done_count, 1);

        // RIGHT, then drop enable while the tone is high.
        start_cmd(TD_RIGHT);
        check_val("right_dir", cur_dir, TD_RIGHT);
        go_to(9999);  check_val("right_9999", tone, 1);
        go_to(10000); check_val("right_10000", tone, 0);
        go_to(19999); check_val("right_19999", tone, 0);
        go_to(20000); check_val("right_20000", tone, 1);
        en = 1'b0;
        step(1);
        check_val("dis_tone", tone, 0);
        check_val("dis_busy", busy, 0);
        check_val("dis_dir", cur_dir, TD_HOLD);
        check_val("dis_ready", ready, 0);
        step(40);
        check_val("dis_no_done", done_count, 1);
        en = 1'b1;
        step(1);

        // FORWARD, then asynchronous reset while the tone is high.
        start_cmd(TD_FORWARD);
        check_val("fwd_dir", cur_dir, TD_FORWARD);
        go_to(16666); check_val("fwd_16666", tone, 1);
        #2 rst = 1'b0;
        #1;
        check_idle("rst_burst");
        step(3);
        rst = 1'b1;
        #1;
        check_val("rst_release_ready", ready, 1);
        step(1);

        // STOP with a RIGHT request arriving while busy.
        start_cmd(TD_STOP);
        go_to(100);
        dir = TD_RIGHT; valid = 1'b1;
        #1;
        check_val("stop_busy_ready", ready, PREEMPT ? 1 : 0);
        step(1);
        if (PREEMPT) valid = 1'b0;
        go_to(10200);
        check_val("stop_10200_tone", tone, PREEMPT ? 0 : 1);
        check_val("stop_10200_dir", cur_dir, PREEMPT ? TD_RIGHT : TD_STOP);
        valid = 1'b0;
        go_to(24999); check_val("stop_24999", tone, 1);
        go_to(25000); check_val("stop_25000", tone, PREEMPT ? 1 : 0);
        go_to(26150);
        check_val("stop_gap_busy", busy, 1);
        check_val("stop_gap_tone", tone, 0);
        #2 rst = 1'b0;
        #1;
        check_idle("rst_gap");
        step(3);
        rst = 1'b1;
        step(300);
        check_val("rst_gap_no_done", done_count, 1);
        check_val("rst_gap_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency; documentation only, with no effect on the RTL.
REQ-002 Parameter BURST_CYCLES, default 30_000_000, tone duration in clocks; must exceed the 25_000_000-cycle detector integration window.
REQ-003 Parameter GAP_CYCLES, default 5_000_000, silent guard interval after each burst, in clocks.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 enableToneGen  input  1  high = generator allowed to accept and transmit.
REQ-007 cmdValid  input  1  command request, held until accepted.
REQ-008 cmdDir  input  3  direction, using the TD_* codes from parameters.vh.
REQ-009 cmdReady  output  1  generator can accept a command this cycle.
REQ-010 toneOut  output  1  square-wave tone to the speaker driver.
REQ-011 busy  output  1  high in BURST or GAP.
REQ-012 curDir  output  3  direction being transmitted; TD_HOLD when idle.
REQ-013 donePulse  output  1  one-cycle pulse at the end of GAP.
REQ-014 badCmd  output  1  one-cycle pulse when a command without a tone mapping is accepted.

Function
REQ-015 The FSM SHALL have three states: IDLE, BURST and GAP.
REQ-016 cmdReady SHALL equal (state==IDLE) && enableToneGen, combinationally.
REQ-017 A command is accepted on a rising edge with cmdValid && cmdReady; cmdDir is captured only on acceptance.
REQ-018 Half-period mapping in clocks: TD_STOP 25000 (1 kHz); TD_FORWARD 16667 (1.5 kHz); TD_LEFT 12500 (2 kHz); TD_RIGHT 10000 (2.5 kHz); TD_REVERSE 8333 (3 kHz).
REQ-019 Accepting any other code (including TD_HOLD) SHALL pulse badCmd the next cycle and leave the FSM in IDLE.
REQ-020 Accepting a mapped code: the next cycle enters BURST with toneOut=1, the half-period counter at 0, the burst counter at 0, and curDir set to the code.
REQ-021 In BURST, toneOut SHALL toggle when the half-period counter reaches HALF-1; the counter then wraps to 0.
REQ-022 BURST SHALL last exactly BURST_CYCLES clocks, then enter GAP with toneOut=0 and the gap counter at 0.
REQ-023 GAP SHALL last exactly GAP_CYCLES clocks, with toneOut held at 0; on the last GAP cycle, go to IDLE and assert donePulse for one cycle.
REQ-024 Counters: half-period counter 15 bits; burst and gap counters 25 bits; no overflow at the default parameter values.
REQ-025 If enableToneGen goes low in any state, the next edge SHALL force IDLE, toneOut=0, curDir=TD_HOLD, and all counters to 0, with no donePulse.
REQ-026 If cmdValid is asserted while busy, it SHALL be ignored (not accepted) unless TONE_GEN_PREEMPT_EN applies.
REQ-027 toneOut, busy, curDir, donePulse and badCmd SHALL be registered outputs; toneOut SHALL be glitch-free.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, toneOut=0, curDir=TD_HOLD, donePulse=0, badCmd=0, all counters 0.
REQ-029 Reset asserted mid-BURST SHALL silence toneOut immediately, with no donePulse afterwards.
REQ-030 After rst deasserts, the first command SHALL be acceptable on the first edge at which enableToneGen=1.

Configuration
REQ-031 Macro TONE_GEN_PREEMPT_EN: when defined, cmdReady SHALL also be high in BURST and GAP (gated by enableToneGen); an accepted mapped command restarts BURST exactly as in REQ-020 with the new curDir, and an accepted unmapped command pulses badCmd with no state change.
REQ-032 When TONE_GEN_PREEMPT_EN is undefined, cmdReady SHALL be low whenever busy=1.

Verification
REQ-033 Reset, then accept TD_LEFT -> toneOut period of 25000 clocks (12500 high / 12500 low); busy high for 35_000_000 clocks; donePulse at cycle 35_000_001 after acceptance.
REQ-034 Accept TD_REVERSE with BURST_CYCLES=100_000 -> toneOut toggles every 8333 clocks; toneOut=0 from cycle 100_001 onward.
REQ-035 Accept TD_HOLD -> badCmd pulse one cycle later; busy stays 0; toneOut stays 0.
REQ-036 Drop enableToneGen mid-BURST -> next edge toneOut=0, busy=0, curDir=TD_HOLD, no donePulse.
REQ-037 Assert cmdValid=TD_RIGHT while busy on TD_STOP -> without macro: cmdReady=0 and TD_STOP completes; with TONE_GEN_PREEMPT_EN: BURST restarts at 2.5 kHz.
REQ-038 Drive rst low mid-GAP -> all outputs reach their reset values without a clock edge.
